// File: rtl/sram_stream_reader_if.sv
// Stream-reader bus: command/status, SRAM port-1 read channel and the output stream.
// The reader uses the master modport; its environment uses slave.
interface sram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;

    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;

    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  start, base_addr, length, dout1, m_ready,
        output busy, done, csb1, addr1, m_data, m_valid
    );

    modport slave (
        output start, base_addr, length, dout1, m_ready,
        input  busy, done, csb1, addr1, m_data, m_valid
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Reads a contiguous SRAM range through port 1 and streams the words out in address
// order, hiding the one-cycle read latency behind a 2-entry output buffer.
module sram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    sram_stream_reader_if.master bus
);
    localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] nxt_addr_q, nxt_addr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  inflight_q;

    logic                  v0_q, v0_d;
    logic                  v1_q, v1_d;
    logic [DATA_WIDTH-1:0] b0_q, b0_d;
    logic [DATA_WIDTH-1:0] b1_q, b1_d;

    logic                  pop_c;
    logic                  push_c;
    logic                  issue_c;
    logic [1:0]            credit_c;

    assign pop_c  = v0_q & bus.m_ready;
    assign push_c = inflight_q;

    // A pop in this cycle frees its slot before the new read can land, so counting it
    // as a credit keeps the stream at one word per cycle without ever overfilling.
    assign credit_c = 2'(v0_q) + 2'(v1_q) + 2'(inflight_q) - 2'(pop_c);
    assign issue_c  = (state_q == ISSUE) && (credit_c < 2'd2);

    assign bus.csb1    = ~issue_c;
    assign bus.addr1   = issue_c ? nxt_addr_q : last_addr_q;
    assign bus.m_valid = v0_q;
    assign bus.m_data  = b0_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // Transfer control: command acceptance, issue bookkeeping and completion.
    always_comb begin
        state_d     = state_q;
        nxt_addr_d  = nxt_addr_q;
        last_addr_d = last_addr_q;
        rem_d       = rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        nxt_addr_d = bus.base_addr;
                        rem_d      = bus.length;
                        busy_d     = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (issue_c) begin
                    last_addr_d = nxt_addr_q;
                    nxt_addr_d  = nxt_addr_q + ADDR_WIDTH'(1);
                    rem_d       = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Final word leaving with nothing behind it ends the transfer.
                if (!inflight_q && !v1_q && pop_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Two-entry output buffer; head entry drives the stream.
    always_comb begin
        b0_d = b0_q;
        b1_d = b1_q;
        v0_d = v0_q;
        v1_d = v1_q;

        unique case ({push_c, pop_c})
            2'b01: begin
                b0_d = b1_q;
                v0_d = v1_q;
                v1_d = 1'b0;
            end
            2'b10: begin
                if (!v0_q) begin
                    b0_d = bus.dout1;
                    v0_d = 1'b1;
                end else begin
                    b1_d = bus.dout1;
                    v1_d = 1'b1;
                end
            end
            2'b11: begin
                if (v1_q) begin
                    b0_d = b1_q;
                    b1_d = bus.dout1;
                end else begin
                    b0_d = bus.dout1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nxt_addr_q  <= '0;
            last_addr_q <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            b0_q        <= '0;
            b1_q        <= '0;
        end else begin
            state_q     <= state_d;
            nxt_addr_q  <= nxt_addr_d;
            last_addr_q <= last_addr_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            inflight_q  <= issue_c;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
        end
    end

    // A returning read must always find a free slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push_c && v1_q) |-> pop_c);

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed self-checking bench for sram_stream_reader with a behavioural SRAM port 1.
module tb_sram_stream_reader;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic clk;
    logic rst_n;

    sram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    sram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];

    // SRAM port 1: data for a read issued at an edge appears after that edge; otherwise junk.
    always @(posedge clk) begin
        if (!ifc.csb1) ifc.dout1 <= mem[ifc.addr1];
        else           ifc.dout1 <= $urandom;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Ready driver: either a fixed level or a repeating 1,0,0,1,0,1 pattern.
    logic       rdy_mode  = 1'b0;
    logic       rdy_level = 1'b1;
    logic [5:0] pat       = 6'b101001;
    int         rdy_idx   = 0;
    initial ifc.m_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            ifc.m_ready = pat[rdy_idx];
            rdy_idx     = (rdy_idx == 5) ? 0 : rdy_idx + 1;
        end else begin
            ifc.m_ready = rdy_level;
        end
    end

    // Monitor, sampled mid-cycle.
    int            cyc = 0;
    logic [DW-1:0] got_q[$];
    int            hs_edge[$];
    int            addr_log[$];
    int            done_cnt = 0;
    int            done_edge = 0;
    int            iss = 0;
    int            acc = 0;
    int            max_out = 0;
    int            hold_err = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && (!ifc.m_valid || ifc.m_data !== prev_data)) hold_err++;
            prev_stall = ifc.m_valid && !ifc.m_ready;
            prev_data  = ifc.m_data;
            if (iss - acc > max_out) max_out = iss - acc;
            if (ifc.m_valid && ifc.m_ready) begin
                got_q.push_back(ifc.m_data);
                hs_edge.push_back(cyc + 1);
                acc++;
            end
            if (!ifc.csb1) begin
                addr_log.push_back(int'(ifc.addr1));
                iss++;
            end
            if (ifc.done) begin
                done_cnt++;
                done_edge = cyc;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_mon();
        got_q.delete();
        hs_edge.delete();
        addr_log.delete();
        done_cnt = 0;
        iss      = 0;
        acc      = 0;
        max_out  = 0;
        hold_err = 0;
    endtask

    task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l);
        @(posedge clk); #1;
        ifc.start     = 1'b1;
        ifc.base_addr = b;
        ifc.length    = l;
        @(posedge clk); #1;
        ifc.start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_csb1"},    32'(ifc.csb1),    32'd1);
        check({pfx, "_addr1"},   32'(ifc.addr1),   32'd0);
        check({pfx, "_m_valid"}, 32'(ifc.m_valid), 32'd0);
        check({pfx, "_m_data"},  32'(ifc.m_data),  32'd0);
        check({pfx, "_busy"},    32'(ifc.busy),    32'd0);
        check({pfx, "_done"},    32'(ifc.done),    32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        ifc.start     = 1'b0;
        ifc.base_addr = '0;
        ifc.length    = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;
        #12;
        check_reset_outputs("rst");
        @(negedge clk); rst_n = 1'b1;

        // Full-rate read of four words.
        @(posedge clk); #1; clear_mon();
        start_xfer(10'd0, 11'd4);
        @(negedge clk);
        check("t1_e0_csb1",  32'(ifc.csb1),    32'd0);
        check("t1_e0_addr1", 32'(ifc.addr1),   32'd0);
        check("t1_e0_busy",  32'(ifc.busy),    32'd1);
        check("t1_e0_valid", 32'(ifc.m_valid), 32'd0);
        @(negedge clk);
        check("t1_e1_valid", 32'(ifc.m_valid), 32'd0);
        check("t1_e1_addr1", 32'(ifc.addr1),   32'd1);
        @(negedge clk);
        check("t1_e2_valid", 32'(ifc.m_valid), 32'd1);
        check("t1_e2_data",  ifc.m_data,       32'h1111_1111);
        wait_done(50);
        check("t1_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            check("t1_w0", got_q[0], 32'h1111_1111);
            check("t1_w1", got_q[1], 32'h2222_2222);
            check("t1_w2", got_q[2], 32'h3333_3333);
            check("t1_w3", got_q[3], 32'h4444_4444);
            check("t1_back_to_back", 32'(hs_edge[3] - hs_edge[0]), 32'd3);
            check("t1_done_after_last", 32'(done_edge), 32'(hs_edge[3]));
        end
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_busy_after", 32'(ifc.busy), 32'd0);
        check("t1_max_out", 32'(max_out <= 2), 32'd1);

        // Same read under a toggling ready.
        clear_mon();
        rdy_idx = 0; rdy_mode = 1'b1;
        start_xfer(10'd0, 11'd4);
        wait_done(100);
        rdy_mode = 1'b0;
        check("t2_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            check("t2_w0", got_q[0], 32'h1111_1111);
            check("t2_w1", got_q[1], 32'h2222_2222);
            check("t2_w2", got_q[2], 32'h3333_3333);
            check("t2_w3", got_q[3], 32'h4444_4444);
        end
        check("t2_max_out",  32'(max_out <= 2), 32'd1);
        check("t2_hold",     32'(hold_err),     32'd0);
        check("t2_done_cnt", 32'(done_cnt),     32'd1);

        // Address wrap past the top word.
        mem[1022] = 32'hA; mem[1023] = 32'hB; mem[0] = 32'hC;
        @(posedge clk); #1; clear_mon();
        start_xfer(10'd1022, 11'd3);
        wait_done(50);
        check("t3_addr_cnt", 32'(addr_log.size()), 32'd3);
        check("t3_data_cnt", 32'(got_q.size()),    32'd3);
        if (addr_log.size() == 3 && got_q.size() == 3) begin
            check("t3_a0", 32'(addr_log[0]), 32'd1022);
            check("t3_a1", 32'(addr_log[1]), 32'd1023);
            check("t3_a2", 32'(addr_log[2]), 32'd0);
            check("t3_d0", got_q[0], 32'hA);
            check("t3_d1", got_q[1], 32'hB);
            check("t3_d2", got_q[2], 32'hC);
        end

        // Zero-length command.
        clear_mon();
        start_xfer(10'd5, 11'd0);
        @(negedge clk);
        check("t4_done",  32'(ifc.done),    32'd1);
        check("t4_busy",  32'(ifc.busy),    32'd0);
        check("t4_csb1",  32'(ifc.csb1),    32'd1);
        check("t4_valid", 32'(ifc.m_valid), 32'd0);
        @(negedge clk);
        check("t4_done_off", 32'(ifc.done), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("t4_no_reads", 32'(addr_log.size()), 32'd0);
        check("t4_no_words", 32'(got_q.size()),    32'd0);
        check("t4_done_cnt", 32'(done_cnt),        32'd1);

        // Start while busy is ignored.
        for (int i = 0; i < 8; i++) mem[i] = 32'h0000_0100 + 32'(i);
        clear_mon();
        start_xfer(10'd0, 11'd8);
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.base_addr = 10'd100; ifc.length = 11'd3;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        wait_done(80);
        check("t5_count", 32'(got_q.size()),    32'd8);
        check("t5_addrs", 32'(addr_log.size()), 32'd8);
        if (got_q.size() == 8 && addr_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t5_w%0d", i), got_q[i], 32'h0000_0100 + 32'(i));
                check($sformatf("t5_a%0d", i), 32'(addr_log[i]), 32'(i));
            end
        end
        check("t5_done_cnt", 32'(done_cnt), 32'd1);

        // Reset in the middle of a transfer, then a fresh short transfer.
        clear_mon();
        start_xfer(10'd0, 11'd8);
        for (int n = 0; n < 40 && got_q.size() < 3; n++) begin
            @(negedge clk); #1;
        end
        check("t6_three_words", 32'(got_q.size() >= 3), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1; clear_mon();
        start_xfer(10'd4, 11'd2);
        wait_done(50);
        check("t6_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("t6_w0", got_q[0], 32'h0000_0104);
            check("t6_w1", got_q[1], 32'h0000_0105);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
